// File: rtl/clock_divider_pkg.sv
// Shared definitions for the run-time clock divider controller:
// state encoding, default counter width and the reset divide-ratio helper.
package clock_divider_pkg;

  localparam int DIV_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Half-period length in system clocks for a requested output frequency.
  // A zero request falls back to the fastest legal ratio instead of dividing by zero.
  function automatic int unsigned calc_default_div(input int unsigned sys_hz,
                                                   input int unsigned req_hz);
    if (req_hz == 32'd0) begin
      calc_default_div = 32'd1;
    end else begin
      calc_default_div = sys_hz / (req_hz * 32'd2);
    end
  endfunction

endpackage

// File: rtl/clock_divider_ctrl_counter.sv
// Half-period counter: counts up while running, wraps to zero on the
// terminal count and is held at zero whenever the divider is not running.
module half_period_counter
  import clock_divider_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             tc
);

  logic [DIV_W-1:0] count_d;
  logic [DIV_W-1:0] count_q;

  // Terminal count uses >= so a count can never run past div-1.
  assign tc = (count_q >= (div - DIV_W'(1)));

  // Next count: clear when stopped or at terminal count, otherwise increment.
  always_comb begin
    count_d = count_q;
    if (!run) begin
      count_d = '0;
    end else if (tc) begin
      count_d = '0;
    end else begin
      count_d = count_q + DIV_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_divider_ctrl.sv
// Run-time controller for a half-period clock divider. Handles start/stop
// sequencing and defers new divide ratios to a toggle boundary so the
// divided clock never shows a runt pulse.
module clock_divider_ctrl
  import clock_divider_pkg::*;
#(
  parameter int unsigned system_freq   = 100_000_000,
  parameter int unsigned required_freq = 50_000,
  parameter int          DIV_W         = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV   = calc_default_div(system_freq, required_freq)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             out,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] div_cur
);

  localparam logic [DIV_W-1:0] DEFAULT_DIV_V = DEFAULT_DIV[DIV_W-1:0];

  state_e           state_d, state_q;
  logic             out_d, out_q;
  logic             tick_d, tick_q;
  logic             cfg_err_d, cfg_err_q;
  logic             pend_d, pend_q;
  logic             busy_d, busy_q;
  logic             ready_d, ready_q;
  logic [DIV_W-1:0] shadow_d, shadow_q;
  logic [DIV_W-1:0] div_cur_d, div_cur_q;

  logic tc;
  logic toggle;
  logic cnt_run;
  logic xfer;

  half_period_counter #(.DIV_W(DIV_W)) u_counter (
    .clk   (clk),
    .reset (reset),
    .run   (cnt_run),
    .div   (div_cur_q),
    .tc    (tc)
  );

  // Next-state logic and toggle decision. A stop request while out is high
  // finishes the high half; one while out is low stops at once.
  always_comb begin
    state_d = state_q;
    toggle  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (en) begin
          toggle  = tc;
          state_d = RUN;
        end else if (!out_q) begin
          state_d = IDLE;
        end else if (tc) begin
          toggle  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      STOP: begin
        toggle = tc;
        if (en) begin
          state_d = RUN;
        end else if (tc) begin
          state_d = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Counter only runs while staying active, so entering RUN starts from zero.
    cnt_run = (state_q != IDLE) && (state_d != IDLE);
  end

  // Output, handshake and ratio bookkeeping.
  always_comb begin
    xfer      = cfg_valid && ready_q;
    tick_d    = toggle;
    cfg_err_d = xfer && (cfg_div == '0);
    div_cur_d = div_cur_q;
    shadow_d  = shadow_q;
    pend_d    = pend_q;

    if (state_d == IDLE) begin
      out_d = 1'b0;
    end else if (toggle) begin
      out_d = ~out_q;
    end else begin
      out_d = out_q;
    end

    // A pending ratio lands on a toggle or when the divider goes idle. A
    // transfer can only happen with nothing pending, so the two never collide.
    if (pend_q && (toggle || (state_d == IDLE))) begin
      div_cur_d = shadow_q;
      pend_d    = 1'b0;
    end else if (xfer && (cfg_div != '0)) begin
      if ((state_q == IDLE) || (state_d == IDLE)) begin
        div_cur_d = cfg_div;
      end else begin
        shadow_d = cfg_div;
        pend_d   = 1'b1;
      end
    end else begin
      pend_d = pend_q;
    end

    busy_d  = (state_d != IDLE);
    ready_d = !pend_d;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      pend_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      shadow_q  <= '0;
      div_cur_q <= DEFAULT_DIV_V;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      shadow_q  <= shadow_d;
      div_cur_q <= div_cur_d;
    end
  end

  assign out       = out_q;
  assign tick      = tick_q;
  assign cfg_err   = cfg_err_q;
  assign busy      = busy_q;
  assign cfg_ready = ready_q;
  assign div_cur   = div_cur_q;

endmodule
